// File: rtl/ecc_apb_pkg.sv
// ecc_apb_pkg: shared types and constants for the ECC APB requester.
//   apb_state_e  - requester FSM states
//   *_ADDR       - ECC block register offsets
//   ctrl_op_e    - op codes written into the CTRL register
package ecc_apb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    ACCESS    = 2'd2,
    WAIT_DONE = 2'd3
  } apb_state_e;

  localparam logic [31:0] ECC_CTRL_ADDR       = 32'h0000_0000;
  localparam logic [31:0] DATA_IN_ADDR        = 32'h0000_0004;
  localparam logic [31:0] CODEWORD_WIDTH_ADDR = 32'h0000_0008;
  localparam logic [31:0] NOISE_ADDR          = 32'h0000_000C;

  typedef enum logic [1:0] {
    OP_ENC  = 2'd0,
    OP_DEC  = 2'd1,
    OP_FULL = 2'd2
  } ctrl_op_e;

endpackage

// File: rtl/ecc_done_watchdog.sv
// ecc_done_watchdog: bounds the time spent waiting for operation_done.
// Only built when ECC_APB_TIMEOUT_EN is defined.
//   clk, rst   - clock and synchronous active-high reset
//   load_i     - WAIT_DONE entry: load TIMEOUT_CYCLES-1
//   run_i      - currently in WAIT_DONE: count down
//   expired_o  - count has reached zero while waiting
module ecc_done_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload on entry, otherwise saturate at zero while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (run_i && (cnt_q != {CW{1'b0}})) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle holding zero is the last WAIT_DONE cycle, giving TIMEOUT_CYCLES in total.
  assign expired_o = run_i && (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/ecc_apb_txn_master.sv
// ecc_apb_txn_master: single-outstanding APB requester for the ECC block.
// One command at a time goes IDLE -> SETUP -> ACCESS -> IDLE; a write to the
// CTRL register additionally waits in WAIT_DONE for operation_done.
// Optional macro ECC_APB_TIMEOUT_EN bounds WAIT_DONE to TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata  command handshake from stimulus layer
//   rsp_valid/rdata/timeout           completion pulse, read data, timeout flag
//   psel/penable/pwrite/paddr/pwdata  APB request (all registered)
//   prdata                            APB read data (zero-wait-state slave)
//   operation_done                    ECC core completion pulse
//   busy                              requester not idle
module ecc_apb_txn_master
  import ecc_apb_pkg::*;
#(
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_timeout,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic [AMBA_WORD-1:0]       pwdata,
  input  logic [AMBA_WORD-1:0]       prdata,
  input  logic                       operation_done,
  output logic                       busy
);

  apb_state_e                 state_q, state_d;
  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q, pwrite_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
  logic                       cmd_ready_q, cmd_ready_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                       rsp_timeout_q, rsp_timeout_d;
  logic                       busy_q, busy_d;
  logic                       accept_s;
  logic                       ctrl_wr_s;
  logic                       expired_s;

  assign accept_s  = cmd_valid && cmd_ready_q;
  // pwrite_q holds the command direction during SETUP/ACCESS.
  assign ctrl_wr_s = pwrite_q && (paddr_q == AMBA_ADDR_WIDTH'(ECC_CTRL_ADDR));

`ifdef ECC_APB_TIMEOUT_EN
  ecc_done_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .load_i    ((state_q == ACCESS) && (state_d == WAIT_DONE)),
    .run_i     (state_q == WAIT_DONE),
    .expired_o (expired_s)
  );
`else
  logic [31:0] tmo_unused_s;
  assign tmo_unused_s = 32'(TIMEOUT_CYCLES);
  assign expired_s    = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d       = state_q;
    psel_d        = 1'b0;
    penable_d     = 1'b0;
    pwrite_d      = 1'b1;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        pwrite_d  = pwrite_q;
      end
      ACCESS: begin
        if (!pwrite_q) begin
          rsp_rdata_d = prdata;
        end else begin
          rsp_rdata_d = rsp_rdata_q;
        end
        // A done pulse coinciding with the CTRL access already completes it.
        if (ctrl_wr_s && !operation_done) begin
          state_d = WAIT_DONE;
        end else begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          cmd_ready_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (operation_done) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          cmd_ready_d = 1'b1;
        end else if (expired_s) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          cmd_ready_d   = 1'b1;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b1;
      paddr_q       <= {AMBA_ADDR_WIDTH{1'b0}};
      pwdata_q      <= {AMBA_WORD{1'b0}};
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {AMBA_WORD{1'b0}};
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ecc_apb_txn_master.sv
// Directed bench for ecc_apb_txn_master. Outputs are sampled 1 time unit
// after each rising edge; inputs change at the same point.
module tb_ecc_apb_txn_master;

`ifdef ECC_APB_TIMEOUT_EN
  localparam int unsigned TMO        = 8;
  localparam int          DONE_DELAY = 5;
`else
  localparam int unsigned TMO        = 1024;
  localparam int          DONE_DELAY = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [19:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [19:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        operation_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  ecc_apb_txn_master #(
    .AMBA_WORD       (32),
    .AMBA_ADDR_WIDTH (20),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_timeout    (rsp_timeout),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .operation_done (operation_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one command for exactly one edge; the requester must be ready.
  task automatic send(input string tag, input logic wr, input logic [19:0] addr,
                      input logic [31:0] data);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0;
  endtask

  initial begin
    rst            = 1'b1;
    cmd_valid      = 1'b0;
    cmd_write      = 1'b0;
    cmd_addr       = 20'h0;
    cmd_wdata      = 32'h0;
    prdata         = 32'h0;
    operation_done = 1'b0;
    tick();
    tick();

    // Reset state.
    chk("rst_psel",    32'(psel),        32'd0);
    chk("rst_penable", 32'(penable),     32'd0);
    chk("rst_pwrite",  32'(pwrite),      32'd1);
    chk("rst_paddr",   32'(paddr),       32'd0);
    chk("rst_pwdata",  pwdata,           32'd0);
    chk("rst_ready",   32'(cmd_ready),   32'd0);
    chk("rst_rspv",    32'(rsp_valid),   32'd0);
    chk("rst_rdata",   rsp_rdata,        32'd0);
    chk("rst_tmo",     32'(rsp_timeout), 32'd0);
    chk("rst_busy",    32'(busy),        32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // operation_done while idle is ignored.
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    chk("idle_done_rspv", 32'(rsp_valid), 32'd0);
    chk("idle_done_busy", 32'(busy),      32'd0);

    // 1. Plain write to DATA_IN.
    send("t1", 1'b1, 20'h00004, 32'hA5A5_0001);
    chk("t1_setup_psel",    32'(psel),      32'd1);
    chk("t1_setup_penable", 32'(penable),   32'd0);
    chk("t1_setup_pwrite",  32'(pwrite),    32'd1);
    chk("t1_setup_paddr",   32'(paddr),     32'h4);
    chk("t1_setup_pwdata",  pwdata,         32'hA5A5_0001);
    chk("t1_setup_ready",   32'(cmd_ready), 32'd0);
    chk("t1_setup_busy",    32'(busy),      32'd1);
    tick();
    chk("t1_acc_psel",    32'(psel),      32'd1);
    chk("t1_acc_penable", 32'(penable),   32'd1);
    chk("t1_acc_rspv",    32'(rsp_valid), 32'd0);
    tick();
    chk("t1_rsp_valid",   32'(rsp_valid),   32'd1);
    chk("t1_rsp_tmo",     32'(rsp_timeout), 32'd0);
    chk("t1_rsp_psel",    32'(psel),        32'd0);
    chk("t1_rsp_penable", 32'(penable),     32'd0);
    chk("t1_rsp_busy",    32'(busy),        32'd0);
    tick();
    chk("t1_rspv_pulse",  32'(rsp_valid),   32'd0);

    // 2. Read DATA_IN.
    prdata = 32'hA5A5_0001;
    send("t2", 1'b0, 20'h00004, 32'h0);
    chk("t2_setup_pwrite", 32'(pwrite), 32'd0);
    chk("t2_setup_psel",   32'(psel),   32'd1);
    tick();
    chk("t2_acc_pwrite",   32'(pwrite),  32'd0);
    chk("t2_acc_penable",  32'(penable), 32'd1);
    tick();
    prdata = 32'hDEAD_BEEF;
    chk("t2_rsp_valid",  32'(rsp_valid), 32'd1);
    chk("t2_rsp_rdata",  rsp_rdata,      32'hA5A5_0001);
    chk("t2_idle_pwrite", 32'(pwrite),   32'd1);
    tick();
    chk("t2_rdata_hold", rsp_rdata,      32'hA5A5_0001);

    // 3. CTRL write, done arrives after a wait.
    send("t3", 1'b1, 20'h00000, 32'h0000_0001);
    tick();
    chk("t3_acc_ready", 32'(cmd_ready), 32'd0);
    tick();
    for (int i = 0; i < DONE_DELAY - 1; i++) begin
      chk("t3_wait_ready", 32'(cmd_ready), 32'd0);
      chk("t3_wait_rspv",  32'(rsp_valid), 32'd0);
      chk("t3_wait_busy",  32'(busy),      32'd1);
      tick();
    end
    chk("t3_wait_psel", 32'(psel), 32'd0);
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    chk("t3_rsp_valid", 32'(rsp_valid),   32'd1);
    chk("t3_rsp_tmo",   32'(rsp_timeout), 32'd0);
    chk("t3_rsp_busy",  32'(busy),        32'd0);
    tick();
    chk("t3_rspv_pulse", 32'(rsp_valid), 32'd0);

    // 4. CTRL write with done during ACCESS: no WAIT_DONE.
    send("t4", 1'b1, 20'h00000, 32'h0000_0002);
    tick();
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t4_busy",      32'(busy),      32'd0);
    chk("t4_ready",     32'(cmd_ready), 32'd1);
    tick();
    chk("t4_rspv_pulse", 32'(rsp_valid), 32'd0);
    chk("t4_busy_after", 32'(busy),      32'd0);

`ifdef ECC_APB_TIMEOUT_EN
    // 5. CTRL write with no done: timeout after TMO waiting cycles.
    send("t5", 1'b1, 20'h00000, 32'h0000_0000);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t5_wait_rspv", 32'(rsp_valid), 32'd0);
      chk("t5_wait_busy", 32'(busy),      32'd1);
      tick();
    end
    chk("t5_rsp_valid", 32'(rsp_valid),   32'd1);
    chk("t5_rsp_tmo",   32'(rsp_timeout), 32'd1);
    send("t5b", 1'b1, 20'h00008, 32'h0000_0010);
    tick();
    tick();
    chk("t5b_rsp_valid", 32'(rsp_valid),   32'd1);
    chk("t5b_rsp_tmo",   32'(rsp_timeout), 32'd0);
    tick();
`endif

    // 6. Reset during ACCESS aborts the transfer.
    prdata = 32'h1234_5678;
    send("t6", 1'b0, 20'h0000C, 32'h0);
    tick();
    chk("t6_acc_penable", 32'(penable), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_psel",    32'(psel),      32'd0);
    chk("t6_rst_penable", 32'(penable),   32'd0);
    chk("t6_rst_pwrite",  32'(pwrite),    32'd1);
    chk("t6_rst_rspv",    32'(rsp_valid), 32'd0);
    chk("t6_rst_rdata",   rsp_rdata,      32'd0);
    chk("t6_rst_busy",    32'(busy),      32'd0);
    tick();
    chk("t6_after_rspv",  32'(rsp_valid), 32'd0);
    send("t6b", 1'b1, 20'h0000C, 32'h0000_0003);
    chk("t6b_paddr",  32'(paddr), 32'hC);
    chk("t6b_pwdata", pwdata,     32'h0000_0003);
    tick();
    tick();
    chk("t6b_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
